spi_slave_engine: RTL and testbench

SPI responder that sits on the far side of the SPI wire crossbar. It lets an on-chip master-side test harness, or a loopback path, terminate one of the switched SPI buses. It oversamples the bus wires (sck, ss_L, mosi) in the system clock domain. It shifts a preloaded word out on miso while capturing the word on mosi, then hands the captured word to the fabric with an armed/finished handshake that the kernel controls.

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_slave_engine_if.sv | 27 ++
 rtl/spi_sync.sv | 28 ++
 rtl/spi_slave_engine.sv | 183 ++++++++++++++++++
 tb/tb_spi_slave_engine.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI responder: FSM state encoding
// and the width of the bit counter.
package spi_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Bit counter width for transfers of up to 32 bits.
    localparam int CNT_W = 5;

endpackage

// File: rtl/spi_slave_engine_if.sv
// Bus and fabric handshake bundle of the SPI responder.
// master: drives sck/ss_L/mosi/to_master/arm; slave: the responder.
interface spi_slave_engine_if #(
    parameter int WID = 24
);

    logic           sck;
    logic           ss_L;
    logic           mosi;
    logic           miso;
    logic [WID-1:0] to_master;
    logic [WID-1:0] from_master;
    logic           arm;
    logic           finished;
    logic           err;

    modport master (
        output sck, ss_L, mosi, to_master, arm,
        input  miso, from_master, finished, err
    );

    modport slave (
        input  sck, ss_L, mosi, to_master, arm,
        output miso, from_master, finished, err
    );

endinterface

// File: rtl/spi_sync.sv
// Two-flop synchronizer with async active-low reset.
// Ports: clk, rst_L, rst_val (reset level), d (async in), q (synced out).
module spi_sync (
    input  logic clk,
    input  logic rst_L,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic [1:0] s_q;
    logic [1:0] s_d;

    always_comb begin
        s_d = {s_q[0], d};
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            s_q <= {2{rst_val}};
        end else begin
            s_q <= s_d;
        end
    end

    assign q = s_q[1];

endmodule

// File: rtl/spi_slave_engine.sv
// SPI responder: oversamples sck/ss_L/mosi, shifts a word out on miso,
// captures mosi. Ports: clk, rst_L, bus (spi_slave_engine_if.slave).
module spi_slave_engine
    import spi_pkg::*;
#(
    parameter int WID      = 24,
    parameter bit POLARITY = 1'b0,
    parameter bit PHASE    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_L,
    spi_slave_engine_if.slave bus
);

    // One extra bit so a full 32-bit count is distinct from zero.
    localparam int             CW   = CNT_W + 1;
    localparam logic [CW-1:0]  FULL = CW'(WID);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    logic           sck_s;
    logic           ss_s;
    logic           mosi_s;
    logic           sck_h_q;
    logic           ss_h_q;

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [WID-1:0] tx_q, tx_d;
    logic [WID-1:0] rx_q, rx_d;
    logic [WID-1:0] from_q, from_d;
    logic           miso_q, miso_d;
    logic           fin_q, fin_d;
    logic           err_q, err_d;
    logic           ovf_q, ovf_d;

    logic           lead;
    logic           trail;
    logic           smp;
    logic           shf;
    logic           ss_fall;
    logic           ss_rise;

    spi_sync u_sck (
        .clk     (clk),
        .rst_L   (rst_L),
        .rst_val (POLARITY),
        .d       (bus.sck),
        .q       (sck_s)
    );

    spi_sync u_ss (
        .clk     (clk),
        .rst_L   (rst_L),
        .rst_val (1'b1),
        .d       (bus.ss_L),
        .q       (ss_s)
    );

    spi_sync u_mosi (
        .clk     (clk),
        .rst_L   (rst_L),
        .rst_val (1'b0),
        .d       (bus.mosi),
        .q       (mosi_s)
    );

    always_comb begin
        lead    = (sck_h_q == POLARITY) && (sck_s != POLARITY);
        trail   = (sck_h_q != POLARITY) && (sck_s == POLARITY);
        smp     = PHASE ? trail : lead;
        shf     = PHASE ? lead : trail;
        ss_fall = ss_h_q && !ss_s;
        ss_rise = !ss_h_q && ss_s;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        from_d  = from_q;
        miso_d  = miso_q;
        fin_d   = fin_q;
        err_d   = err_q;
        ovf_d   = ovf_q;

        if (!bus.arm) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            miso_d  = 1'b0;
            fin_d   = 1'b0;
            err_d   = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    miso_d = 1'b0;
                    cnt_d  = '0;
                    fin_d  = 1'b0;
                    err_d  = 1'b0;
                    ovf_d  = 1'b0;
                    if (ss_fall) begin
                        state_d = ST_ACTIVE;
                        rx_d    = '0;
                        if (PHASE) begin
                            tx_d = bus.to_master;
                        end else begin
                            // CPHA=0: MSB must be on the wire
                            // before the first leading edge.
                            miso_d = bus.to_master[WID-1];
                            tx_d   = {bus.to_master[WID-2:0], 1'b0};
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (smp) begin
                        if (cnt_q == FULL) begin
                            err_d  = 1'b1;
                            ovf_d  = 1'b1;
                            miso_d = 1'b0;
                        end else begin
                            rx_d  = {rx_q[WID-2:0], mosi_s};
                            cnt_d = cnt_q + ONE;
                        end
                    end
                    if (shf) begin
                        miso_d = tx_q[WID-1] && !ovf_q;
                        tx_d   = {tx_q[WID-2:0], 1'b0};
                    end
                    // Uses the _d values so a same-cycle sample counts.
                    if (ss_rise) begin
                        from_d  = rx_d;
                        fin_d   = 1'b1;
                        err_d   = err_d || (cnt_d != FULL);
                        miso_d  = 1'b0;
                        ovf_d   = 1'b0;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            sck_h_q <= POLARITY;
            ss_h_q  <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            from_q  <= '0;
            miso_q  <= 1'b0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sck_h_q <= sck_s;
            ss_h_q  <= ss_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            from_q  <= from_d;
            miso_q  <= miso_d;
            fin_q   <= fin_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.miso        = miso_q;
    assign bus.from_master = from_q;
    assign bus.finished    = fin_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_spi_slave_engine.sv
// Self-checking bench: four responders (one per SPI mode), a bus master
// task and a word-level model of what each transfer must produce.
module tb_spi_slave_engine;

    localparam int WID = 24;

    logic           clk       = 1'b0;
    logic           rst_L     = 1'b0;
    logic           sck_act   = 1'b0;
    logic           ss_L      = 1'b1;
    logic           mosi      = 1'b0;
    logic           arm       = 1'b0;
    logic [WID-1:0] to_master = '0;
    int             mode      = 0;

    wire  [3:0]     miso_a;
    wire  [3:0]     fin_a;
    wire  [3:0]     err_a;
    wire  [WID-1:0] from_a [4];

    int             tests     = 0;
    int             fails     = 0;
    bit             chk_en    = 1'b0;
    bit             chk_err   = 1'b1;
    bit             in_xfer   = 1'b0;
    logic           exp_fin   = 1'b0;
    logic           exp_err   = 1'b0;
    logic [WID-1:0] exp_from  = '0;
    logic [WID-1:0] got;

    always #5 clk = ~clk;

    // Instance g runs mode (POLARITY,PHASE) = (g/2, g%2); sck_act is
    // the bus clock with idle level 0, inverted for POLARITY=1.
    for (genvar g = 0; g < 4; g++) begin : gm
        spi_slave_engine_if #(.WID(WID)) ifc ();
        assign ifc.sck       = (g >= 2) ? ~sck_act : sck_act;
        assign ifc.ss_L      = ss_L;
        assign ifc.mosi      = mosi;
        assign ifc.to_master = to_master;
        assign ifc.arm       = arm && (mode == g);
        assign miso_a[g]     = ifc.miso;
        assign fin_a[g]      = ifc.finished;
        assign err_a[g]      = ifc.err;
        assign from_a[g]     = ifc.from_master;
        spi_slave_engine #(
            .WID      (WID),
            .POLARITY (g >= 2),
            .PHASE    (g % 2 == 1)
        ) dut (
            .clk   (clk),
            .rst_L (rst_L),
            .bus   (ifc)
        );
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [WID-1:0] act,
                        input logic [WID-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Half sck period: 4 clk, ending 2 time units after a rising clk.
    task automatic hp();
        repeat (4) @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk1("finished", fin_a[mode], exp_fin);
            if (chk_err) chk1("err", err_a[mode], exp_err);
            if (exp_fin) chkw("from_master", from_a[mode], exp_from);
            if (!in_xfer) chk1("miso_idle", miso_a[mode], 1'b0);
            for (int k = 0; k < 4; k++) begin
                if (k != mode) begin
                    chk1("other_miso", miso_a[k], 1'b0);
                    chk1("other_fin", fin_a[k], 1'b0);
                end
            end
        end
    end

    task automatic rearm(input int md);
        @(posedge clk);
        #2 arm = 1'b0;
        @(posedge clk);
        exp_fin = 1'b0;
        exp_err = 1'b0;
        #2 mode = md;
        @(posedge clk);
        #2 arm = 1'b1;
        @(posedge clk);
        #2;
    endtask

    // n sck pulses; st holds the n mosi bits, first bit at st[n-1].
    task automatic xfer(input int n, input logic [WID-1:0] tx,
                        input logic [31:0] st, input int abort_at,
                        input int rst_at, output logic [WID-1:0] rcv);
        bit   pha;
        bit   live;
        bit   stop;
        logic eb;
        logic b;
        int   k;
        pha       = mode[0];
        live      = arm;
        stop      = 1'b0;
        rcv       = '0;
        to_master = tx;
        chk_err   = (n <= WID);
        mosi      = pha ? 1'b0 : st[n-1];
        @(posedge clk);
        #2;
        in_xfer = 1'b1;
        ss_L    = 1'b0;
        hp();
        for (int i = 0; i < n; i++) begin
            if (!stop) begin
                if (i == abort_at) begin
                    arm  = 1'b0;
                    live = 1'b0;
                    hp();
                end
                if (i == rst_at) begin
                    rst_L    = 1'b0;
                    in_xfer  = 1'b0;
                    exp_fin  = 1'b0;
                    exp_err  = 1'b0;
                    exp_from = '0;
                    #1;
                    chk1("rst_async_miso", miso_a[mode], 1'b0);
                    chk1("rst_async_fin", fin_a[mode], 1'b0);
                    chk1("rst_async_err", err_a[mode], 1'b0);
                    chkw("rst_async_from", from_a[mode], '0);
                    @(posedge clk);
                    #1;
                    chk1("rst_edge_miso", miso_a[mode], 1'b0);
                    chkw("rst_edge_from", from_a[mode], '0);
                    sck_act = 1'b0;
                    ss_L    = 1'b1;
                    mosi    = 1'b0;
                    hp();
                    rst_L = 1'b1;
                    stop  = 1'b1;
                end else begin
                    eb = (live && i < WID) ? tx[WID-1-i] : 1'b0;
                    if (!pha) begin
                        b       = miso_a[mode];
                        sck_act = 1'b1;
                        hp();
                        sck_act = 1'b0;
                        mosi    = (i + 1 < n) ? st[n-2-i] : 1'b0;
                        hp();
                    end else begin
                        sck_act = 1'b1;
                        mosi    = st[n-1-i];
                        hp();
                        b       = miso_a[mode];
                        sck_act = 1'b0;
                        hp();
                    end
                    chk1("miso_bit", b, eb);
                    if (i < WID) rcv[WID-1-i] = b;
                end
            end
        end
        if (!stop) begin
            ss_L = 1'b1;
            mosi = 1'b0;
            repeat (3) @(posedge clk);
            in_xfer = 1'b0;
            if (live) begin
                k        = (n < WID) ? n : WID;
                exp_fin  = 1'b1;
                exp_err  = (n != WID);
                exp_from = WID'(st >> (n - k));
            end
            #2;
        end
        chk_err = 1'b1;
    endtask

    initial begin
        #2_000_000;
        fails++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int          md;
        int          n;
        logic [31:0] st;
        logic [WID-1:0] tx;

        repeat (3) @(posedge clk);
        #2;
        for (int k = 0; k < 4; k++) begin
            chk1("reset_miso", miso_a[k], 1'b0);
            chk1("reset_fin", fin_a[k], 1'b0);
            chk1("reset_err", err_a[k], 1'b0);
            chkw("reset_from", from_a[k], '0);
        end
        rst_L  = 1'b1;
        chk_en = 1'b1;

        rearm(0);
        xfer(24, 24'hA5C3F0, 32'h123456, -1, -1, got);
        chkw("m0_master_rx", got, 24'hA5C3F0);
        chkw("m0_from", from_a[0], 24'h123456);
        chk1("m0_fin", fin_a[0], 1'b1);
        chk1("m0_err", err_a[0], 1'b0);

        @(posedge clk);
        #2 arm = 1'b0;
        @(posedge clk);
        exp_fin = 1'b0;
        exp_err = 1'b0;
        #1;
        chk1("drop_fin", fin_a[0], 1'b0);
        chkw("drop_keep_from", from_a[0], 24'h123456);

        for (int m = 1; m < 4; m++) begin
            rearm(m);
            xfer(24, 24'h800001, 32'hFFFFFE, -1, -1, got);
            chkw("mode_master_rx", got, 24'h800001);
            chkw("mode_from", from_a[m], 24'hFFFFFE);
            chk1("mode_err", err_a[m], 1'b0);
        end

        rearm(0);
        xfer(20, 24'h654321, 32'h000ABCDE, -1, -1, got);
        chk1("short_fin", fin_a[0], 1'b1);
        chk1("short_err", err_a[0], 1'b1);
        chkw("short_from", from_a[0], 24'h0ABCDE);

        rearm(0);
        xfer(26, 24'hC0FFEE, {6'b0, 24'hABCDEF, 2'b10}, -1, -1, got);
        chkw("long_master_rx", got, 24'hC0FFEE);
        chk1("long_fin", fin_a[0], 1'b1);
        chk1("long_err", err_a[0], 1'b1);
        chkw("long_from", from_a[0], 24'hABCDEF);

        for (int r = 0; r < 8; r++) begin
            md = int'($urandom_range(0, 3));
            n  = (r % 2 == 0) ? WID : int'($urandom_range(18, 28));
            tx = WID'($urandom);
            st = $urandom & ((32'd1 << n) - 32'd1);
            rearm(md);
            xfer(n, tx, st, -1, -1, got);
        end

        rearm(0);
        @(posedge clk);
        #2 arm = 1'b0;
        xfer(24, 24'hFFFFFF, 32'h00F00F, -1, -1, got);
        chk1("unarmed_fin", fin_a[0], 1'b0);
        chkw("unarmed_rx", got, 24'h000000);

        rearm(0);
        xfer(24, 24'h111111, 32'h5A5A5A, -1, -1, got);
        chkw("pre_abort_from", from_a[0], 24'h5A5A5A);
        rearm(0);
        xfer(24, 24'hFFFFFF, 32'h0F0F0F, 10, -1, got);
        chkw("abort_from", from_a[0], 24'h5A5A5A);
        chk1("abort_fin", fin_a[0], 1'b0);

        rearm(0);
        xfer(24, 24'hFFFFFF, 32'h333333, -1, 10, got);
        xfer(24, 24'h00FF00, 32'h00FF00, -1, -1, got);
        chkw("post_rst_master_rx", got, 24'h00FF00);
        chkw("post_rst_from", from_a[0], 24'h00FF00);
        chk1("post_rst_fin", fin_a[0], 1'b1);
        chk1("post_rst_err", err_a[0], 1'b0);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
